pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register for the five-stage MIPS core. It carries PC, instruction word and branch-delay flag between adjacent stages (F/D, D/E, E/M, M/W).
- Replaces the plain enable-gated stage register with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush that inserts a NOP bubble.
- Lets stall propagation be registered (no combinational ready path from out_ready to in_ready) without losing in-flight instructions.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_slot.sv | 62 ++++++
 rtl/pipe_stage_reg.sv | 180 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
// Used by pipe_slot and pipe_stage_reg.
package pipe_pkg;

    localparam int          STATS_W    = 16;
    localparam int          DEF_DATA_W = 32;
    localparam int          DEF_PC_W   = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // Beat layout at the default core widths; modules with other widths build an equivalent local type.
    typedef struct packed {
        logic                  valid;
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_DATA_W-1:0] instr;
        logic                  bd;
    } pipe_beat_t;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] value);
        return (&value) ? value : value + STATS_W'(1);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register {valid, pc, instr, bd} of a pipeline stage.
// Clear has priority over load; a cleared slot holds a NOP at RESET_PC.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic              bd_i,
    output logic              valid_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [DATA_W-1:0] instr_o,
    output logic              bd_o
);

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] instr;
        logic              bd;
    } beat_t;

    localparam beat_t SLOT_CLEAR = '{
        valid: 1'b0,
        pc:    RESET_PC,
        instr: DATA_W'(NOP_INSTR),
        bd:    1'b0
    };

    beat_t beat_q;
    beat_t beat_d;

    always_comb begin
        beat_d = beat_q;
        if (clear_i) begin
            beat_d = SLOT_CLEAR;
        end else if (load_i) begin
            beat_d = '{valid: 1'b1, pc: pc_i, instr: instr_i, bd: bd_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q <= SLOT_CLEAR;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign valid_o = beat_q.valid;
    assign pc_o    = beat_q.pc;
    assign instr_o = beat_q.instr;
    assign bd_o    = beat_q.bd;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer and flush-to-bubble.
// Define PIPE_STAGE_STATS_EN to add the stall_cycles / flush_count statistics ports.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [DATA_W-1:0]  in_instr,
    input  logic               in_bd,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [DATA_W-1:0]  out_instr,
    output logic               out_bd
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STATS_W-1:0] stall_cycles,
    output logic [STATS_W-1:0] flush_count
`endif
);

    pipe_state_t state_q;
    pipe_state_t state_d;
    logic        in_ready_q;
    logic        in_ready_d;

    logic in_fire;
    logic out_fire;
    logic main_load;
    logic main_clear;
    logic skid_load;
    logic skid_clear;

    logic              skid_valid;
    logic [PC_W-1:0]   skid_pc;
    logic [DATA_W-1:0] skid_instr;
    logic              skid_bd;

    logic [PC_W-1:0]   main_pc_in;
    logic [DATA_W-1:0] main_instr_in;
    logic              main_bd_in;

    // in_ready comes from a flop so downstream stalls never ripple combinationally upstream.
    assign in_ready = in_ready_q & ~reset;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Main refills from the skid slot whenever it holds the older beat.
    assign main_pc_in    = skid_valid ? skid_pc    : in_pc;
    assign main_instr_in = skid_valid ? skid_instr : in_instr;
    assign main_bd_in    = skid_valid ? skid_bd    : in_bd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        if (flush) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end else if (out_fire) begin
                        main_clear = 1'b1;
                        state_d    = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_load  = 1'b1;
                        skid_clear = 1'b1;
                        state_d    = ONE;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end

        in_ready_d = (state_d != FULL);
    end

    pipe_slot #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .load_i  (main_load),
        .clear_i (main_clear),
        .pc_i    (main_pc_in),
        .instr_i (main_instr_in),
        .bd_i    (main_bd_in),
        .valid_o (out_valid),
        .pc_o    (out_pc),
        .instr_o (out_instr),
        .bd_o    (out_bd)
    );

    pipe_slot #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (in_pc),
        .instr_i (in_instr),
        .bd_i    (in_bd),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr),
        .bd_o    (skid_bd)
    );

`ifdef PIPE_STAGE_STATS_EN
    logic [STATS_W-1:0] stall_cycles_q;
    logic [STATS_W-1:0] flush_count_q;

    // Counters survive flushes; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                stall_cycles_q <= sat_inc(stall_cycles_q);
            end
            if (flush && (out_valid || skid_valid)) begin
                flush_count_q <= sat_inc(flush_count_q);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    // Statistics disabled: no counter state is built.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed-vector and scoreboard bench for pipe_stage_reg.
// Statistics checks are compiled in when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_reg;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] I0 = 32'h2408_0001;
    localparam logic [31:0] I1 = 32'h2409_0002;
    localparam logic [31:0] I2 = 32'h240A_0003;
    localparam logic [31:0] I3 = 32'h240B_0004;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_bd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_bd;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W   (32),
        .PC_W     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_bd     (in_bd),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_bd    (out_bd)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
        logic        fl;
        logic        ordy;
        logic        e_ov;
        logic        e_pc_chk;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_bd;
        logic        e_ir;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                       input logic bd, input logic fl, input logic ordy,
                       input logic e_ov, input logic e_pc_chk, input logic [31:0] e_pc,
                       input logic [31:0] e_instr, input logic e_bd, input logic e_ir);
        vec_t v;
        v.iv = iv; v.pc = pc; v.instr = instr; v.bd = bd; v.fl = fl; v.ordy = ordy;
        v.e_ov = e_ov; v.e_pc_chk = e_pc_chk; v.e_pc = e_pc;
        v.e_instr = e_instr; v.e_bd = e_bd; v.e_ir = e_ir;
        vq.push_back(v);
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
    } beat_t;

    beat_t model_q[$];

    initial begin
        reset = 1'b1; in_valid = 1'b1; in_pc = 32'h3000; in_instr = I0; in_bd = 1'b0;
        flush = 1'b0; out_ready = 1'b1;

        // Stream, stall absorption, delay-slot flag, flush in FULL, flush with in/out fire.
        add(1, 32'h3000, I0, 0, 0, 1,  1, 1, 32'h3000, I0, 0, 1);
        add(1, 32'h3004, I1, 0, 0, 1,  1, 1, 32'h3004, I1, 0, 1);
        add(1, 32'h3008, I2, 0, 0, 1,  1, 1, 32'h3008, I2, 0, 1);
        add(0, 32'h0,    0,  0, 0, 1,  0, 0, 32'h0,    0,  0, 1);
        add(1, 32'h3000, I0, 0, 0, 0,  1, 1, 32'h3000, I0, 0, 1);
        add(1, 32'h3004, I1, 0, 0, 0,  1, 1, 32'h3000, I0, 0, 0);
        add(1, 32'h3008, I2, 0, 0, 0,  1, 1, 32'h3000, I0, 0, 0);
        add(0, 32'h0,    0,  0, 0, 1,  1, 1, 32'h3004, I1, 0, 1);
        add(0, 32'h0,    0,  0, 0, 1,  0, 0, 32'h0,    0,  0, 1);
        add(1, 32'h3000, I0, 0, 0, 1,  1, 1, 32'h3000, I0, 0, 1);
        add(1, 32'h3004, 0,  1, 0, 1,  1, 1, 32'h3004, 0,  1, 1);
        add(1, 32'h3008, I2, 0, 0, 1,  1, 1, 32'h3008, I2, 0, 1);
        add(0, 32'h0,    0,  0, 0, 1,  0, 0, 32'h0,    0,  0, 1);
        add(1, 32'h3000, I0, 0, 0, 0,  1, 1, 32'h3000, I0, 0, 1);
        add(1, 32'h3004, I1, 0, 0, 0,  1, 1, 32'h3000, I0, 0, 0);
        add(1, 32'h3008, I2, 0, 1, 0,  0, 1, RST_PC,   0,  0, 1);
        add(0, 32'h0,    0,  0, 0, 1,  0, 1, RST_PC,   0,  0, 1);
        add(1, 32'h300C, I3, 1, 0, 0,  1, 1, 32'h300C, I3, 1, 1);
        add(1, 32'h3000, I0, 0, 1, 1,  0, 1, RST_PC,   0,  0, 1);
        add(0, 32'h0,    0,  0, 0, 1,  0, 1, RST_PC,   0,  0, 1);

        // Reset held with a beat offered upstream.
        repeat (3) @(posedge clk);
        #1;
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.out_instr", out_instr, 32'd0);
        check("rst.out_bd",    {31'b0, out_bd}, 32'd0);
        check("rst.out_pc",    out_pc, RST_PC);
        check("rst.in_ready",  {31'b0, in_ready}, 32'd0);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst.in_ready", {31'b0, in_ready}, 32'd1);

        foreach (vq[i]) begin
            in_valid = vq[i].iv; in_pc = vq[i].pc; in_instr = vq[i].instr; in_bd = vq[i].bd;
            flush = vq[i].fl; out_ready = vq[i].ordy;
            @(posedge clk);
            #1;
            $display("vec %0d: iv=%0b pc=%h fl=%0b ordy=%0b -> ov=%0b pc=%h instr=%h bd=%0b ir=%0b",
                     i, vq[i].iv, vq[i].pc, vq[i].fl, vq[i].ordy, out_valid, out_pc, out_instr, out_bd, in_ready);
            check($sformatf("v%0d.out_valid", i), {31'b0, out_valid}, {31'b0, vq[i].e_ov});
            check($sformatf("v%0d.in_ready", i),  {31'b0, in_ready},  {31'b0, vq[i].e_ir});
            check($sformatf("v%0d.out_instr", i), out_instr, vq[i].e_instr);
            check($sformatf("v%0d.out_bd", i),    {31'b0, out_bd},    {31'b0, vq[i].e_bd});
            if (vq[i].e_pc_chk) begin
                check($sformatf("v%0d.out_pc", i), out_pc, vq[i].e_pc);
            end
        end

        // Random handshake traffic against a FIFO scoreboard; the tail drains the stage.
        begin
            logic [31:0] next_pc;
            logic        exp_ir;
            logic        f_in;
            logic        f_out;
            beat_t       b;
            next_pc = 32'h4000;
            flush = 1'b0;
            for (int c = 0; c < 320; c++) begin
                in_valid  = (c < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
                out_ready = (c < 300) ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_pc     = next_pc;
                in_instr  = ~next_pc;
                in_bd     = next_pc[2];
                exp_ir    = (model_q.size() < 2);
                check($sformatf("rnd%0d.in_ready", c), {31'b0, in_ready}, {31'b0, exp_ir});
                check($sformatf("rnd%0d.out_valid", c), {31'b0, out_valid},
                      {31'b0, (model_q.size() > 0)});
                if (model_q.size() > 0) begin
                    check($sformatf("rnd%0d.out_pc", c), out_pc, model_q[0].pc);
                    check($sformatf("rnd%0d.out_instr", c), out_instr, model_q[0].instr);
                    check($sformatf("rnd%0d.out_bd", c), {31'b0, out_bd}, {31'b0, model_q[0].bd});
                end else begin
                    check($sformatf("rnd%0d.out_instr_nop", c), out_instr, 32'd0);
                end
                f_in  = in_valid && exp_ir;
                f_out = out_ready && (model_q.size() > 0);
                @(posedge clk);
                if (f_out) begin
                    b = model_q.pop_front();
                    $display("rnd %0d: consumed pc=%h", c, b.pc);
                end
                if (f_in) begin
                    model_q.push_back('{pc: next_pc, instr: ~next_pc, bd: next_pc[2]});
                    next_pc = next_pc + 32'd4;
                end
                #1;
            end
            check("drain.out_valid", {31'b0, out_valid}, 32'd0);
            check("drain.model_empty", model_q.size(), 32'd0);
        end

`ifdef PIPE_STAGE_STATS_EN
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("stats.rst_stall", {16'b0, stall_cycles}, 32'd0);
        check("stats.rst_flush", {16'b0, flush_count}, 32'd0);
        in_valid = 1'b1; in_pc = 32'h3000; in_instr = I0; in_bd = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stats.stall5", {16'b0, stall_cycles}, 32'd5);
        repeat (69995) @(posedge clk);
        #1;
        $display("stats: stall_cycles=%h after 70000 stalled cycles", stall_cycles);
        check("stats.stall_sat", {16'b0, stall_cycles}, 32'h0000_FFFF);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("stats.flush_one", {16'b0, flush_count}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("stats.flush_empty", {16'b0, flush_count}, 32'd1);
        check("stats.stall_kept", {16'b0, stall_cycles}, 32'h0000_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
